// File: rtl/classify_sequencer.sv
// Run-level sequencer: clears the network, waits for end-of-inference, scans the digit scores
// through a shared select mux and publishes the argmax digit over a valid/ready handshake.
module classify_sequencer #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 32,
    parameter int IDX_W       = 4,
    parameter int SEL_LATENCY = 1,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      net_clear_o,
    input  logic                      net_done_i,
    output logic [IDX_W-1:0]          score_sel_o,
    input  logic signed [SCORE_W-1:0] score_in_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [IDX_W-1:0]          result_digit_o,
    output logic signed [SCORE_W-1:0] result_score_o,
    output logic                      timeout_err_o,
    output logic [15:0]               infer_count_o,
    output logic [2:0]                state_o
);

    localparam int SCAN_CYC = NUM_CLASSES + SEL_LATENCY;
    localparam int CNT_W    = $clog2(SCAN_CYC + 1);
    localparam int TMR_W    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_WAIT    = 3'd2,
        S_SCAN    = 3'd3,
        S_PUBLISH = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           best_idx_q, best_idx_d;
    logic signed [SCORE_W-1:0]  best_score_q, best_score_d;
    logic [IDX_W-1:0]           res_digit_q, res_digit_d;
    logic signed [SCORE_W-1:0]  res_score_q, res_score_d;
    logic                       timeout_q, timeout_d;
    logic [15:0]                count_q, count_d;

    // Capture position lags the select counter by the mux latency; negative means not yet valid.
    int   cap_pos;
    logic cap_en;
    assign cap_pos = int'(cnt_q) - SEL_LATENCY;
    assign cap_en  = (cap_pos >= 0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            res_digit_q  <= '0;
            res_score_q  <= '0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            res_digit_q  <= res_digit_d;
            res_score_q  <= res_score_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        res_digit_d  = res_digit_q;
        res_score_d  = res_score_q;
        timeout_d    = timeout_q;
        count_d      = count_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_CLEAR;
                    timeout_d = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (net_done_i) begin
                    state_d = S_SCAN;
                    cnt_d   = '0;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_SCAN: begin
                cnt_d = cnt_q + 1'b1;
                // Strict greater-than keeps the lowest index on ties.
                if (cap_en && (cap_pos == 0 || score_in_i > best_score_q)) begin
                    best_idx_d   = IDX_W'(cap_pos);
                    best_score_d = score_in_i;
                end
                if (cnt_q == CNT_W'(SCAN_CYC - 1)) begin
                    state_d     = S_PUBLISH;
                    res_digit_d = best_idx_d;
                    res_score_d = best_score_d;
                end
            end
            S_PUBLISH: begin
                // Transfer occurs on a clock edge where result_valid and result_ready are both 1;
                // valid is held with stable data until then and drops the cycle after.
                if (result_ready_i) begin
                    state_d = S_IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        score_sel_o = '0;
        if (state_q == S_SCAN) begin
            if (int'(cnt_q) < NUM_CLASSES) score_sel_o = IDX_W'(cnt_q);
            else                           score_sel_o = IDX_W'(NUM_CLASSES - 1);
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign net_clear_o    = (state_q == S_CLEAR);
    assign result_valid_o = (state_q == S_PUBLISH);
    assign result_digit_o = res_digit_q;
    assign result_score_o = res_score_q;
    assign timeout_err_o  = timeout_q;
    assign infer_count_o  = count_q;
    assign state_o        = state_q;

endmodule
